// File: rtl/multicycle_control.sv
// multicycle_control
//
// Control FSM for the multi-cycle RV32I core. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). The FSM drives the datapath
// selects, the write-enable strobes, the memory request and the 5-bit ALU
// opcode. All outputs are decoded combinationally from the state register
// and the instruction register contents.
//
// Parameters:
//   ILLEGAL_HALT  1: illegal opcodes and SYSTEM instructions enter HALT
//                 0: they retire as a NOP (PC <= PC+4)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   instr         instruction register contents
//   branch_cond   ALU result bit 0, used in EXECUTE of a branch
//   mem_ready     memory completes the current request
//   mem_req       memory request
//   mem_we        1 = store, 0 = load
//   mem_addr_sel  0 = PC, 1 = registered ALU output
//   ir_we         load the instruction register
//   pc_we         load the PC
//   rf_we         register file write
//   pc_src        0 = PC+4, 1 = PC+imm, 2 = {alu_result[31:1],1'b0}
//   alu_a_sel     0 = rs1, 1 = PC, 2 = zero
//   alu_b_sel     0 = rs2, 1 = imm, 2 = constant 4
//   wb_sel        0 = ALU output, 1 = memory data, 2 = PC+4
//   alu_op        ALU opcode
//   halted        FSM is in HALT

module multicycle_control #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_cond,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic [4:0]  alu_op,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_BEQ   = 5'd10;
    localparam logic [4:0] ALU_AUIPC = 5'd12;
    localparam logic [4:0] ALU_BNE   = 5'd13;
    localparam logic [4:0] ALU_BLT   = 5'd14;
    localparam logic [4:0] ALU_BGE   = 5'd15;
    localparam logic [4:0] ALU_BLTU  = 5'd16;
    localparam logic [4:0] ALU_BGEU  = 5'd17;

    state_t state;
    state_t next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic [4:0] arith_op;
    logic [4:0] branch_op;
    logic       branch_legal;
    logic       is_load;
    logic       is_store;

    // Only the opcode, funct3 and bit 30 steer control; the remaining
    // instruction bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign alt      = instr[30];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    // funct3 -> ALU op for OP / OP-IMM. Bit 30 selects SUB only for the
    // register form (in OP-IMM it is part of the immediate), but selects SRA
    // for both forms.
    always_comb begin
        arith_op = ALU_ADD;
        unique case (funct3)
            3'b000: arith_op = (alt && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            3'b111: arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    end

    // funct3 -> branch comparison; 010 and 011 have no branch encoding.
    always_comb begin
        branch_op    = ALU_ADD;
        branch_legal = 1'b1;
        unique case (funct3)
            3'b000: branch_op = ALU_BEQ;
            3'b001: branch_op = ALU_BNE;
            3'b100: branch_op = ALU_BLT;
            3'b101: branch_op = ALU_BGE;
            3'b110: branch_op = ALU_BLTU;
            3'b111: branch_op = ALU_BGEU;
            default: branch_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   next_state = FETCH;
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                unique case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: next_state = WB;
                    OPC_LOAD, OPC_STORE:                    next_state = MEM;
                    OPC_JAL, OPC_JALR:                      next_state = FETCH;
                    OPC_BRANCH: begin
                        if (branch_legal) next_state = FETCH;
                        else              next_state = ILLEGAL_HALT ? HALT : FETCH;
                    end
                    default: next_state = ILLEGAL_HALT ? HALT : FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) next_state = is_load ? WB : FETCH;
            end
            WB:     next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Output decode. Everything defaults to 0 / ADD, so IDLE, DECODE and
    // HALT (apart from halted) need no explicit assignments.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        wb_sel       = 2'd0;
        alu_op       = ALU_ADD;
        halted       = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            EXECUTE: begin
                unique case (opcode)
                    OPC_OP: begin
                        alu_op = arith_op;
                    end
                    OPC_OP_IMM: begin
                        alu_b_sel = 2'd1;
                        alu_op    = arith_op;
                    end
                    OPC_LUI: begin
                        alu_a_sel = 2'd2;
                        alu_b_sel = 2'd1;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 2'd1;
                        alu_op    = ALU_AUIPC;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 2'd1;
                    end
                    OPC_BRANCH: begin
                        if (branch_legal) begin
                            alu_op = branch_op;
                            pc_we  = 1'b1;
                            pc_src = branch_cond ? 2'd1 : 2'd0;
                        end else if (!ILLEGAL_HALT) begin
                            pc_we = 1'b1;
                        end
                    end
                    OPC_JAL: begin
                        rf_we  = 1'b1;
                        wb_sel = 2'd2;
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 2'd1;
                        rf_we     = 1'b1;
                        wb_sel    = 2'd2;
                        pc_we     = 1'b1;
                        pc_src    = 2'd2;
                    end
                    default: begin
                        // Illegal / SYSTEM retires as PC+4 when not halting.
                        if (!ILLEGAL_HALT) pc_we = 1'b1;
                    end
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                // A store retires here; a load retires in WB.
                pc_we        = mem_ready && !is_load;
            end
            WB: begin
                rf_we  = 1'b1;
                wb_sel = is_load ? 2'd1 : 2'd0;
                pc_we  = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//
// Two instances run side by side from the same inputs: one halting on
// illegal instructions, one retiring them as NOPs. Each stimulus step pushes
// the expected outputs of both instances into scoreboard queues; a monitor
// on the falling clock edge pops and compares.

module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic [1:0] pc_src;
        logic [1:0] alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] wb_sel;
        logic [4:0] alu_op;
        logic       halted;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_cond;
    logic        mem_ready;

    out_t act_h;
    out_t act_n;

    int total = 0;
    int bad   = 0;

    string qn[$];
    out_t  qh[$];
    out_t  qnop[$];

    string mon_name;
    out_t  mon_eh;
    out_t  mon_en;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_halt (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .mem_req      (act_h.mem_req),
        .mem_we       (act_h.mem_we),
        .mem_addr_sel (act_h.mem_addr_sel),
        .ir_we        (act_h.ir_we),
        .pc_we        (act_h.pc_we),
        .rf_we        (act_h.rf_we),
        .pc_src       (act_h.pc_src),
        .alu_a_sel    (act_h.alu_a_sel),
        .alu_b_sel    (act_h.alu_b_sel),
        .wb_sel       (act_h.wb_sel),
        .alu_op       (act_h.alu_op),
        .halted       (act_h.halted)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dut_nop (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .mem_req      (act_n.mem_req),
        .mem_we       (act_n.mem_we),
        .mem_addr_sel (act_n.mem_addr_sel),
        .ir_we        (act_n.ir_we),
        .pc_we        (act_n.pc_we),
        .rf_we        (act_n.rf_we),
        .pc_src       (act_n.pc_src),
        .alu_a_sel    (act_n.alu_a_sel),
        .alu_b_sel    (act_n.alu_b_sel),
        .wb_sel       (act_n.wb_sel),
        .alu_op       (act_n.alu_op),
        .halted       (act_n.halted)
    );

    // Builds an expected output vector from hand-computed field values.
    function automatic out_t o(input logic req, input logic we, input logic asel,
                               input logic ir, input logic pcw, input logic rfw,
                               input logic [1:0] pcs, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] wb,
                               input logic [4:0] op, input logic h);
        out_t r;
        r.mem_req      = req;
        r.mem_we       = we;
        r.mem_addr_sel = asel;
        r.ir_we        = ir;
        r.pc_we        = pcw;
        r.rf_we        = rfw;
        r.pc_src       = pcs;
        r.alu_a_sel    = a;
        r.alu_b_sel    = b;
        r.wb_sel       = wb;
        r.alu_op       = op;
        r.halted       = h;
        return r;
    endfunction

    // Drives one cycle of inputs and queues the outputs both instances
    // should show during that cycle.
    task automatic applyStimulus(input string name, input logic rn,
                                 input logic [31:0] ins, input logic rdy,
                                 input logic bc, input out_t e_halt,
                                 input out_t e_nop);
        rst_n       = rn;
        instr       = ins;
        mem_ready   = rdy;
        branch_cond = bc;
        qn.push_back(name);
        qh.push_back(e_halt);
        qnop.push_back(e_nop);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic rn, input logic [31:0] ins,
                        input logic rdy, input logic bc, input out_t e);
        applyStimulus(name, rn, ins, rdy, bc, e, e);
    endtask

    task automatic checkOutput(input string name, input string which,
                               input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s (%s): got %h expected %h", name, which, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (qn.size() > 0) begin
            mon_name = qn.pop_front();
            mon_eh   = qh.pop_front();
            mon_en   = qnop.pop_front();
            checkOutput(mon_name, "halt_dut", act_h, mon_eh);
            checkOutput(mon_name, "nop_dut", act_n, mon_en);
        end
    end

    // Zero-wait ALU-class instruction: FETCH, DECODE, EXECUTE, WB.
    task automatic aluInstr(input string name, input logic [31:0] ins, input out_t ex);
        step({name, "_fetch"},  1'b1, ins, 1'b1, 1'b0, o(1,0,0,1,0,0,0,0,0,0,0,0));
        step({name, "_decode"}, 1'b1, ins, 1'b1, 1'b0, '0);
        step({name, "_exec"},   1'b1, ins, 1'b1, 1'b0, ex);
        step({name, "_wb"},     1'b1, ins, 1'b1, 1'b0, o(0,0,0,0,1,1,0,0,0,0,0,0));
    endtask

    initial begin
        out_t fetch_rdy;
        out_t fetch_wait;
        out_t mem_ld;
        fetch_rdy  = o(1,0,0,1,0,0,0,0,0,0,0,0);
        fetch_wait = o(1,0,0,0,0,0,0,0,0,0,0,0);
        mem_ld     = o(1,0,1,0,0,0,0,0,0,0,0,0);

        rst_n       = 1'b0;
        instr       = 32'h0;
        mem_ready   = 1'b0;
        branch_cond = 1'b0;
        @(posedge clk);
        #1;

        step("reset_hold", 1'b0, 32'h0, 1'b1, 1'b0, '0);
        step("idle",       1'b1, 32'h0, 1'b1, 1'b0, '0);

        aluInstr("add",   32'h00208133, o(0,0,0,0,0,0,0,0,0,0,5'd0,0));
        aluInstr("sub",   32'h40208133, o(0,0,0,0,0,0,0,0,0,0,5'd1,0));
        aluInstr("srai",  32'h4020d113, o(0,0,0,0,0,0,0,0,1,0,5'd7,0));
        aluInstr("auipc", 32'h00001097, o(0,0,0,0,0,0,0,1,1,0,5'd12,0));

        // Load with three memory wait cycles: 8 cycles total.
        step("lw_fetch",  1'b1, 32'h0000a103, 1'b1, 1'b0, fetch_rdy);
        step("lw_decode", 1'b1, 32'h0000a103, 1'b1, 1'b0, '0);
        step("lw_exec",   1'b1, 32'h0000a103, 1'b1, 1'b0, o(0,0,0,0,0,0,0,0,1,0,0,0));
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", 1'b1, 32'h0000a103, 1'b0, 1'b0, mem_ld);
        step("lw_mem_done", 1'b1, 32'h0000a103, 1'b1, 1'b0, mem_ld);
        step("lw_wb",       1'b1, 32'h0000a103, 1'b1, 1'b0, o(0,0,0,0,1,1,0,0,0,1,0,0));

        // Zero-wait store retires from MEM.
        step("sw_fetch",  1'b1, 32'h0020a223, 1'b1, 1'b0, fetch_rdy);
        step("sw_decode", 1'b1, 32'h0020a223, 1'b1, 1'b0, '0);
        step("sw_exec",   1'b1, 32'h0020a223, 1'b1, 1'b0, o(0,0,0,0,0,0,0,0,1,0,0,0));
        step("sw_mem",    1'b1, 32'h0020a223, 1'b1, 1'b0, o(1,1,1,0,1,0,0,0,0,0,0,0));

        // BNE taken, then not taken.
        step("bne_t_fetch",  1'b1, 32'h00209463, 1'b1, 1'b1, fetch_rdy);
        step("bne_t_decode", 1'b1, 32'h00209463, 1'b1, 1'b1, '0);
        step("bne_t_exec",   1'b1, 32'h00209463, 1'b1, 1'b1, o(0,0,0,0,1,0,1,0,0,0,5'd13,0));
        step("bne_n_fetch",  1'b1, 32'h00209463, 1'b1, 1'b0, fetch_rdy);
        step("bne_n_decode", 1'b1, 32'h00209463, 1'b1, 1'b0, '0);
        step("bne_n_exec",   1'b1, 32'h00209463, 1'b1, 1'b0, o(0,0,0,0,1,0,0,0,0,0,5'd13,0));

        step("jal_fetch",   1'b1, 32'h008000ef, 1'b1, 1'b0, fetch_rdy);
        step("jal_decode",  1'b1, 32'h008000ef, 1'b1, 1'b0, '0);
        step("jal_exec",    1'b1, 32'h008000ef, 1'b1, 1'b0, o(0,0,0,0,1,1,1,0,0,2,0,0));
        step("jalr_fetch",  1'b1, 32'h000080e7, 1'b1, 1'b0, fetch_rdy);
        step("jalr_decode", 1'b1, 32'h000080e7, 1'b1, 1'b0, '0);
        step("jalr_exec",   1'b1, 32'h000080e7, 1'b1, 1'b0, o(0,0,0,0,1,1,2,0,1,2,0,0));

        // ECALL: one instance halts, the other retires it as PC+4 and then
        // sits in FETCH because memory never answers.
        step("ecall_fetch",  1'b1, 32'h00000073, 1'b1, 1'b0, fetch_rdy);
        step("ecall_decode", 1'b1, 32'h00000073, 1'b1, 1'b0, '0);
        applyStimulus("ecall_exec", 1'b1, 32'h00000073, 1'b0, 1'b0,
                      '0, o(0,0,0,0,1,0,0,0,0,0,0,0));
        for (int i = 0; i < 10; i++)
            applyStimulus("ecall_after", 1'b1, 32'h00000073, 1'b0, 1'b0,
                          o(0,0,0,0,0,0,0,0,0,0,0,1), fetch_wait);

        // Reset out of HALT, then reset again in the middle of a MEM wait.
        step("rst2_hold", 1'b0, 32'h0, 1'b0, 1'b0, '0);
        step("rst2_idle", 1'b1, 32'h0, 1'b0, 1'b0, '0);
        step("lw2_fetch",  1'b1, 32'h0000a103, 1'b1, 1'b0, fetch_rdy);
        step("lw2_decode", 1'b1, 32'h0000a103, 1'b1, 1'b0, '0);
        step("lw2_exec",   1'b1, 32'h0000a103, 1'b1, 1'b0, o(0,0,0,0,0,0,0,0,1,0,0,0));
        step("lw2_wait",   1'b1, 32'h0000a103, 1'b0, 1'b0, mem_ld);
        step("lw2_wait",   1'b1, 32'h0000a103, 1'b0, 1'b0, mem_ld);
        step("rst3_mid",   1'b0, 32'h0000a103, 1'b0, 1'b0, '0);
        step("rst3_idle",  1'b1, 32'h0000a103, 1'b0, 1'b0, '0);
        step("rst3_fetch", 1'b1, 32'h0000a103, 1'b0, 1'b0, fetch_wait);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 5 && qn.size() > 0; i++)
            @(posedge clk);
        total++;
        if (qn.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", qn.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
